rf_writeback_unit: RTL and testbench

- Sits directly upstream of the 32x32 r0-zero 2r1w register file and drives its single write port.
- Arbitrates round-robin between two val/rdy writeback streams: port 0 is the single-cycle ALU path, port 1 is the multi-cycle mul/load path.
- Registers the granted write into a one-entry output stage.
- Keeps a 32-entry pending-write scoreboard with busy/bypass lookup for the two decode read addresses.

---
 rtl/rf_writeback_unit.sv | 150 +++++++++++++++
 tb/tb_rf_writeback_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_unit.sv
// Writeback arbiter for the 2r1w register file: round-robin merge of the ALU and
// mul/load writeback streams, a one-entry write stage, and a pending-write scoreboard.
module rf_writeback_unit #(
  parameter  int p_data_nbits  = 32,
  parameter  int p_num_entries = 32,
  localparam int c_addr_nbits  = $clog2(p_num_entries)
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    issue_en,
  input  logic [c_addr_nbits-1:0] issue_addr,

  input  logic                    wb0_val,
  output logic                    wb0_rdy,
  input  logic [c_addr_nbits-1:0] wb0_addr,
  input  logic [p_data_nbits-1:0] wb0_data,

  input  logic                    wb1_val,
  output logic                    wb1_rdy,
  input  logic [c_addr_nbits-1:0] wb1_addr,
  input  logic [p_data_nbits-1:0] wb1_data,

  output logic                    wr_en,
  output logic [c_addr_nbits-1:0] wr_addr,
  output logic [p_data_nbits-1:0] wr_data,

  input  logic [c_addr_nbits-1:0] rs0_addr,
  output logic                    rs0_busy,
  output logic                    rs0_byp_val,
  output logic [p_data_nbits-1:0] rs0_byp_data,

  input  logic [c_addr_nbits-1:0] rs1_addr,
  output logic                    rs1_busy,
  output logic                    rs1_byp_val,
  output logic [p_data_nbits-1:0] rs1_byp_data
);

  logic                     last_grant_q;
  logic                     last_grant_d;
  logic                     wr_en_q;
  logic                     wr_en_d;
  logic [c_addr_nbits-1:0]  wr_addr_q;
  logic [c_addr_nbits-1:0]  wr_addr_d;
  logic [p_data_nbits-1:0]  wr_data_q;
  logic [p_data_nbits-1:0]  wr_data_d;
  logic [p_num_entries-1:0] pending_q;
  logic [p_num_entries-1:0] pending_d;

  logic                     grant0;
  logic                     grant1;
  logic                     fire;
  logic [c_addr_nbits-1:0]  sel_addr;
  logic [p_data_nbits-1:0]  sel_data;

  // On contention the port that did not win last time is granted; nothing is
  // accepted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant0 = wb0_val && (!wb1_val || last_grant_q);
      grant1 = wb1_val && (!wb0_val || !last_grant_q);
    end
  end

  assign wb0_rdy  = grant0;
  assign wb1_rdy  = grant1;
  assign fire     = grant0 || grant1;
  assign sel_addr = grant1 ? wb1_addr : wb0_addr;
  assign sel_data = grant1 ? wb1_data : wb0_data;

  // A write to r0 still completes the handshake but leaves the write stage
  // untouched, so wr_addr/wr_data only change alongside a real write.
  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (fire) begin
      last_grant_d = grant1;
      if (sel_addr != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = sel_addr;
        wr_data_d = sel_data;
      end
    end
  end

  // Retire the registered write, then apply a new issue so set wins a tie.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < p_num_entries; i++) begin
      if (wr_en_q && wr_addr_q == c_addr_nbits'(i)) begin
        pending_d[i] = 1'b0;
      end
      if (issue_en && issue_addr == c_addr_nbits'(i) && i != 0) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      pending_q    <= pending_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // The write being presented this cycle is forwarded; r0 never bypasses.
  always_comb begin
    rs0_byp_val  = wr_en_q && wr_addr_q == rs0_addr && rs0_addr != '0;
    rs1_byp_val  = wr_en_q && wr_addr_q == rs1_addr && rs1_addr != '0;
    rs0_byp_data = wr_data_q;
    rs1_byp_data = wr_data_q;
    rs0_busy     = pending_q[rs0_addr] && !rs0_byp_val;
    rs1_busy     = pending_q[rs1_addr] && !rs1_byp_val;
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(wb0_val)) else $error("wb0_val is X");
      assert (!$isunknown(wb1_val)) else $error("wb1_val is X");
      assert (!$isunknown(issue_en)) else $error("issue_en is X");
      if (issue_en) begin
        assert (int'(issue_addr) < p_num_entries) else $error("issue_addr out of range");
      end
      if (wb0_val) begin
        assert (int'(wb0_addr) < p_num_entries) else $error("wb0_addr out of range");
      end
      if (wb1_val) begin
        assert (int'(wb1_addr) < p_num_entries) else $error("wb1_addr out of range");
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed bench for rf_writeback_unit: a transaction-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_rf_writeback_unit;

  logic        clk;
  logic        reset;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        wb0_val;
  logic        wb0_rdy;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb1_val;
  logic        wb1_rdy;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs0_addr;
  logic        rs0_busy;
  logic        rs0_byp_val;
  logic [31:0] rs0_byp_data;
  logic [4:0]  rs1_addr;
  logic        rs1_busy;
  logic        rs1_byp_val;
  logic [31:0] rs1_byp_data;

  int total = 0;
  int bad   = 0;

  rf_writeback_unit dut (
    .clk(clk), .reset(reset),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .wb0_val(wb0_val), .wb0_rdy(wb0_rdy), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_val(wb1_val), .wb1_rdy(wb1_rdy), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs0_addr(rs0_addr), .rs0_busy(rs0_busy), .rs0_byp_val(rs0_byp_val),
    .rs0_byp_data(rs0_byp_data),
    .rs1_addr(rs1_addr), .rs1_busy(rs1_busy), .rs1_byp_val(rs1_byp_val),
    .rs1_byp_data(rs1_byp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    wb0_val = v0; wb0_addr = a0; wb0_data = d0;
    wb1_val = v1; wb1_addr = a1; wb1_data = d1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural view of the write stage, round-robin memory
  // and the set of registers that still have a write in flight.
  bit          mdlReady = 0;
  bit          mdlPending [32];
  int          mdlLast;
  bit          mdlWrEn;
  int          mdlWrAddr;
  logic [31:0] mdlWrData;

  function automatic int predictWinner();
    if (reset) return -1;
    if (wb0_val && wb1_val) return (mdlLast == 0) ? 1 : 0;
    if (wb0_val) return 0;
    if (wb1_val) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int winner;
    int addr;
    if (reset) begin
      foreach (mdlPending[i]) mdlPending[i] = 0;
      mdlLast   = 1;
      mdlWrEn   = 0;
      mdlWrAddr = 0;
      mdlWrData = 0;
      mdlReady  = 1;
    end else if (mdlReady) begin
      winner = predictWinner();
      if (mdlWrEn) mdlPending[mdlWrAddr] = 0;
      if (issue_en && issue_addr != 0) mdlPending[issue_addr] = 1;
      mdlWrEn = 0;
      if (winner >= 0) begin
        mdlLast = winner;
        addr = (winner == 1) ? int'(wb1_addr) : int'(wb0_addr);
        if (addr != 0) begin
          mdlWrEn   = 1;
          mdlWrAddr = addr;
          mdlWrData = (winner == 1) ? wb1_data : wb0_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    int  w;
    bit  byp0, byp1;
    if (mdlReady) begin
      w = predictWinner();
      checkOutput("mdl_rdy0", 32'(wb0_rdy), 32'(w == 0));
      checkOutput("mdl_rdy1", 32'(wb1_rdy), 32'(w == 1));
      checkOutput("mdl_wr_en", 32'(wr_en), 32'(mdlWrEn));
      if (mdlWrEn) begin
        checkOutput("mdl_wr_addr", 32'(wr_addr), 32'(mdlWrAddr));
        checkOutput("mdl_wr_data", wr_data, mdlWrData);
      end
      byp0 = mdlWrEn && mdlWrAddr == int'(rs0_addr) && rs0_addr != 0;
      byp1 = mdlWrEn && mdlWrAddr == int'(rs1_addr) && rs1_addr != 0;
      checkOutput("mdl_rs0_byp", 32'(rs0_byp_val), 32'(byp0));
      checkOutput("mdl_rs1_byp", 32'(rs1_byp_val), 32'(byp1));
      checkOutput("mdl_rs0_busy", 32'(rs0_busy), 32'(mdlPending[rs0_addr] && !byp0));
      checkOutput("mdl_rs1_busy", 32'(rs1_busy), 32'(mdlPending[rs1_addr] && !byp1));
      if (byp0) checkOutput("mdl_rs0_data", rs0_byp_data, mdlWrData);
      if (byp1) checkOutput("mdl_rs1_data", rs1_byp_data, mdlWrData);
    end
  end

  initial begin
    int          idx0, idx1;
    logic        r0, r1;
    logic [4:0]  seq [4];
    logic [4:0]  q0 [2];
    logic [4:0]  q1 [2];
    seq = '{5'd1, 5'd3, 5'd2, 5'd4};
    q0  = '{5'd1, 5'd2};
    q1  = '{5'd3, 5'd4};

    reset = 1; issue_en = 0; issue_addr = 0; rs0_addr = 0; rs1_addr = 0;
    applyStimulus(1, 5'd5, 32'h55, 1, 5'd6, 32'h66);
    step(); step();
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_wr_en", 32'(wr_en), 0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_rdy0", 32'(wb0_rdy), 0);
    checkOutput("rst_rdy1", 32'(wb1_rdy), 0);
    step();
    reset = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();

    $display("[TB] single ALU write");
    applyStimulus(1, 5'd5, 32'h11, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_rdy0", 32'(wb0_rdy), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_wr_en", 32'(wr_en), 1);
    checkOutput("t1_wr_addr", 32'(wr_addr), 5);
    checkOutput("t1_wr_data", wr_data, 32'h11);
    step();
    @(negedge clk);
    checkOutput("t1_wr_en_off", 32'(wr_en), 0);
    step();

    $display("[TB] write to r0");
    rs0_addr = 0;
    applyStimulus(0, 0, 0, 1, 5'd0, 32'hFF);
    @(negedge clk);
    checkOutput("r0_rdy1", 32'(wb1_rdy), 1);
    checkOutput("r0_busy", 32'(rs0_busy), 0);
    checkOutput("r0_byp", 32'(rs0_byp_val), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("r0_wr_en", 32'(wr_en), 0);
    checkOutput("r0_byp_after", 32'(rs0_byp_val), 0);
    step();

    $display("[TB] contention");
    idx0 = 0; idx1 = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(idx0 < 2, (idx0 < 2) ? q0[idx0] : 5'd0, 32'h100 + 32'(idx0),
                    idx1 < 2, (idx1 < 2) ? q1[idx1] : 5'd0, 32'h200 + 32'(idx1));
      @(negedge clk);
      checkOutput($sformatf("rr_rdy0_%0d", k), 32'(wb0_rdy), 32'(k % 2 == 0));
      checkOutput($sformatf("rr_rdy1_%0d", k), 32'(wb1_rdy), 32'(k % 2 == 1));
      if (k > 0) checkOutput($sformatf("rr_wr_addr_%0d", k - 1), 32'(wr_addr), 32'(seq[k-1]));
      r0 = wb0_rdy; r1 = wb1_rdy;
      step();
      if (r0) idx0++;
      if (r1) idx1++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rr_wr_addr_3", 32'(wr_addr), 4);
    checkOutput("rr_wr_data_3", wr_data, 32'h201);
    step();

    $display("[TB] scoreboard r7");
    issue_en = 1; issue_addr = 5'd7; rs0_addr = 5'd7;
    step();
    issue_en = 0;
    applyStimulus(1, 5'd7, 32'hAB, 0, 0, 0);
    @(negedge clk);
    checkOutput("sb_busy_set", 32'(rs0_busy), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("sb_busy_byp", 32'(rs0_busy), 0);
    checkOutput("sb_byp_val", 32'(rs0_byp_val), 1);
    checkOutput("sb_byp_data", rs0_byp_data, 32'hAB);
    step();
    @(negedge clk);
    checkOutput("sb_busy_done", 32'(rs0_busy), 0);
    checkOutput("sb_byp_done", 32'(rs0_byp_val), 0);
    step();

    $display("[TB] set wins over clear");
    rs1_addr = 5'd9;
    applyStimulus(0, 0, 0, 1, 5'd9, 32'h99);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    issue_en = 1; issue_addr = 5'd9;
    @(negedge clk);
    checkOutput("sc_byp1", 32'(rs1_byp_val), 1);
    checkOutput("sc_byp1_data", rs1_byp_data, 32'h99);
    step();
    issue_en = 0;
    @(negedge clk);
    checkOutput("sc_busy1", 32'(rs1_busy), 1);
    step();

    $display("[TB] reset mid-operation");
    issue_en = 1; issue_addr = 5'd3; rs0_addr = 5'd3;
    applyStimulus(1, 5'd12, 32'hC0, 0, 0, 0);
    step();
    issue_en = 0;
    reset = 1;
    applyStimulus(1, 5'd3, 32'h33, 0, 0, 0);
    @(negedge clk);
    checkOutput("mr_rdy0", 32'(wb0_rdy), 0);
    step();
    reset = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("mr_wr_en", 32'(wr_en), 0);
    checkOutput("mr_busy3", 32'(rs0_busy), 0);
    applyStimulus(1, 5'd14, 32'hE0, 1, 5'd15, 32'hF0);
    #1;
    checkOutput("mr_first_rdy0", 32'(wb0_rdy), 1);
    checkOutput("mr_first_rdy1", 32'(wb1_rdy), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("mr_wr_addr", 32'(wr_addr), 14);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
